// File: rtl/acc_out_requant.sv
// Deskews a skewed systolic-array accumulator row, rounds/right-shifts/narrows it and queues
// it in an output row FIFO. Define ACC_OUT_SAT_EN to saturate on narrowing (default: wrap).
module acc_out_requant #(
    parameter int SYS_ARRAY_WIDTH = 8,
    parameter int ACC_WIDTH       = 32,
    parameter int ACT_WIDTH       = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [SYS_ARRAY_WIDTH*ACC_WIDTH-1:0] fact_data_in,
    input  logic [4:0]                           shift_amt,
    input  logic                                 out_ready,
    input  logic                                 err_clr,
    output logic                                 out_valid,
    output logic [SYS_ARRAY_WIDTH*ACT_WIDTH-1:0] out_data,
    output logic                                 fifo_afull,
    output logic                                 busy,
    output logic                                 overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = SYS_ARRAY_WIDTH * ACT_WIDTH;

`ifdef ACC_OUT_SAT_EN
    localparam logic signed [ACC_WIDTH:0] ACT_MAX =
        {{(ACC_WIDTH - ACT_WIDTH + 2){1'b0}}, {(ACT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ACT_MIN =
        {{(ACC_WIDTH - ACT_WIDTH + 2){1'b1}}, {(ACT_WIDTH - 1){1'b0}}};
`endif

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [ACT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                     input logic [4:0]           s);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
`ifdef ACC_OUT_SAT_EN
        logic signed [ACC_WIDTH:0] shf;
`endif
        ext = $signed({x[ACC_WIDTH-1], x});
        rnd = ext;
        if (s != 5'd0) begin
            rnd = ext + $signed((ACC_WIDTH + 1)'(1) << (s - 5'd1));
        end
`ifdef ACC_OUT_SAT_EN
        shf = rnd >>> s;
        if (shf > ACT_MAX) begin
            return ACT_MAX[ACT_WIDTH-1:0];
        end else if (shf < ACT_MIN) begin
            return ACT_MIN[ACT_WIDTH-1:0];
        end
        return shf[ACT_WIDTH-1:0];
`else
        return ACT_WIDTH'(rnd >>> s);
`endif
    endfunction

    // Deskew: column i waits SYS_ARRAY_WIDTH-1-i cycles so the whole row lines up.
    logic [ACC_WIDTH-1:0]     aligned [SYS_ARRAY_WIDTH];
    logic [SYS_ARRAY_WIDTH-2:0] tok_q;
    logic                     row_aligned;
    logic [ROW_W-1:0]         rq_next;

    for (genvar i = 0; i < SYS_ARRAY_WIDTH; i++) begin : g_col
        localparam int DLY = SYS_ARRAY_WIDTH - 1 - i;
        logic [ACC_WIDTH-1:0] col_in;
        assign col_in = fact_data_in[i*ACC_WIDTH +: ACC_WIDTH];

        if (DLY == 0) begin : g_pass
            assign aligned[i] = col_in;
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dly_q [DLY];
            always_ff @(posedge clk) begin
                dly_q[0] <= col_in;
                for (int k = 1; k < DLY; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
            assign aligned[i] = dly_q[DLY-1];
        end

        assign rq_next[i*ACT_WIDTH +: ACT_WIDTH] = requant(aligned[i], shift_amt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_q <= '0;
        end else begin
            tok_q[0] <= in_valid;
            for (int k = 1; k < SYS_ARRAY_WIDTH - 1; k++) begin
                tok_q[k] <= tok_q[k-1];
            end
        end
    end

    assign row_aligned = tok_q[SYS_ARRAY_WIDTH-2];

    logic             rq_valid_q;
    logic [ROW_W-1:0] rq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_valid_q <= 1'b0;
            rq_q       <= '0;
        end else begin
            rq_valid_q <= row_aligned;
            if (row_aligned) begin
                rq_q <= rq_next;
            end
        end
    end

    // Output row FIFO, no bypass path.
    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, pop, wr_en, drop;
    logic             overflow_q;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop   = out_valid & out_ready;
    assign wr_en = rq_valid_q & (~full | pop);
    assign drop  = rq_valid_q & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rq_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A fresh drop outranks a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem[rd_ptr_q] : '0;
    assign fifo_afull   = (count_q >= CNT_W'(FIFO_DEPTH - 1));
    assign busy         = (|tok_q) | rq_valid_q | out_valid;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_acc_out_requant.sv
// Randomized and directed bench for acc_out_requant against a transaction-level row model.
module tb_acc_out_requant;

    localparam int N     = 8;
    localparam int ACC   = 32;
    localparam int ACT   = 8;
    localparam int DEPTH = 4;
    localparam longint SAT_HI = (longint'(1) <<< (ACT - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) <<< (ACT - 1));

    typedef logic [N*ACC-1:0] acc_row_t;
    typedef logic [N*ACT-1:0] act_row_t;
    typedef int row_int_t [N];
    typedef struct {
        int       launch;
        act_row_t exp;
    } pend_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    acc_row_t   fact_data_in = '0;
    logic [4:0] shift_amt = '0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       out_valid;
    act_row_t   out_data;
    logic       fifo_afull;
    logic       busy;
    logic       overflow_err;

    acc_out_requant #(
        .SYS_ARRAY_WIDTH(N),
        .ACC_WIDTH      (ACC),
        .ACT_WIDTH      (ACT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .fact_data_in(fact_data_in),
        .shift_amt   (shift_amt),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .fifo_afull  (fifo_afull),
        .busy        (busy),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail = 0;
    int       edge_cnt = 0;
    pend_t    pending[$];
    act_row_t exp_q[$];
    bit       exp_err = 1'b0;
    acc_row_t hist [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round half up, floor-divide by 2^s, then narrow.
    function automatic logic [ACT-1:0] ref_requant(input logic signed [ACC-1:0] x, input int s);
        longint v;
        v = longint'(x);
        if (s > 0) v = v + (longint'(1) <<< (s - 1));
        v = v >>> s;
`ifdef ACC_OUT_SAT_EN
        if (v > SAT_HI) v = SAT_HI;
        else if (v < SAT_LO) v = SAT_LO;
`endif
        return v[ACT-1:0];
    endfunction

    function automatic act_row_t ref_row(input acc_row_t raw, input int s);
        act_row_t r;
        for (int i = 0; i < N; i++) r[i*ACT +: ACT] = ref_requant(raw[i*ACC +: ACC], s);
        return r;
    endfunction

    function automatic acc_row_t mk_acc(input row_int_t v);
        acc_row_t r;
        for (int i = 0; i < N; i++) r[i*ACC +: ACC] = ACC'(v[i]);
        return r;
    endfunction

    function automatic act_row_t mk_act(input row_int_t v);
        act_row_t r;
        for (int i = 0; i < N; i++) r[i*ACT +: ACT] = ACT'(v[i]);
        return r;
    endfunction

    function automatic acc_row_t rand_row();
        acc_row_t r;
        int c;
        for (int i = 0; i < N; i++) begin
            c = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
            r[i*ACC +: ACC] = ACC'(c);
        end
        return r;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Row model: each launched row lands at the FIFO N+1 edges after it was sampled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            pending.delete();
            exp_err = 1'b0;
        end else begin
            bit do_pop;
            bit drop;
            do_pop = (exp_q.size() != 0) && out_ready;
            drop = 1'b0;
            if (do_pop) void'(exp_q.pop_front());
            if (pending.size() != 0 && pending[0].launch + N == edge_cnt) begin
                if (exp_q.size() == DEPTH) drop = 1'b1;
                else exp_q.push_back(pending[0].exp);
                void'(pending.pop_front());
            end
            if (drop) exp_err = 1'b1;
            else if (err_clr) exp_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit mbusy;
        mbusy = (exp_q.size() != 0);
        foreach (pending[k]) if (pending[k].launch < edge_cnt) mbusy = 1'b1;
        check("out_valid", out_valid, exp_q.size() != 0);
        check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
        check("fifo_afull", fifo_afull, exp_q.size() >= DEPTH - 1);
        check("overflow_err", overflow_err, exp_err);
        check("busy", busy, mbusy);
    end

    // Advance one cycle and drive the skewed columns of every row still in flight.
    task automatic cycle(input bit v, input acc_row_t raw, input bit rdy, input bit clr);
        pend_t p;
        @(posedge clk);
        #1;
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v ? raw : rand_row();
        for (int i = 0; i < N; i++) fact_data_in[i*ACC +: ACC] = hist[i][i*ACC +: ACC];
        in_valid  = v;
        out_ready = rdy;
        err_clr   = clr;
        if (v) begin
            p.launch = edge_cnt;
            p.exp    = ref_row(raw, int'(shift_amt));
            pending.push_back(p);
        end
    endtask

    task automatic run_single(input string tag, input acc_row_t raw, input int s,
                              input act_row_t exp);
        shift_amt = 5'(s);
        cycle(1'b1, raw, 1'b1, 1'b0);
        for (int k = 1; k <= N + 2; k++) begin
            cycle(1'b0, rand_row(), 1'b1, 1'b0);
            @(negedge clk);
            check({tag, "_valid"}, out_valid, k == N + 1);
            if (k == N + 1) check({tag, "_data"}, out_data, exp);
            if (k == N + 2) check({tag, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        row_int_t a, e;
        for (int k = 0; k < N; k++) hist[k] = rand_row();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_afull", fifo_afull, 0);
        check("rst_busy", busy, 0);
        check("rst_err", overflow_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        a = '{10, 20, 30, 40, 50, 60, 70, 80};
        run_single("single", mk_acc(a), 0, mk_act(a));

        a = '{5, 6, -5, -6, 7, -7, 100, -100};
        e = '{1, 2, -1, -1, 2, -2, 25, -25};
        run_single("round_s2", mk_acc(a), 2, mk_act(e));

        a = '{2147483647, 3, -3, 0, 0, 0, 0, 0};
`ifdef ACC_OUT_SAT_EN
        e = '{127, 2, -1, 0, 0, 0, 0, 0};
`else
        e = '{0, 2, -1, 0, 0, 0, 0, 0};
`endif
        run_single("round_max", mk_acc(a), 1, mk_act(e));

        a = '{300, -300, 127, -128, 128, -129, 0, -1};
`ifdef ACC_OUT_SAT_EN
        e = '{127, -128, 127, -128, 127, -128, 0, -1};
`else
        e = '{44, -44, 127, -128, -128, 127, 0, -1};
`endif
        run_single("narrow", mk_acc(a), 0, mk_act(e));

        // Six rows into a stalled four-entry FIFO.
        shift_amt = 5'd3;
        for (int r = 0; r < 6; r++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        for (int c = 0; c < N + 4; c++) cycle(1'b0, rand_row(), 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_afull", fifo_afull, 1);
        check("ovf_set", overflow_err, 1);
        cycle(1'b0, rand_row(), 1'b1, 1'b1);
        for (int c = 0; c < N; c++) cycle(1'b0, rand_row(), 1'b1, 1'b0);
        @(negedge clk);
        check("ovf_clr", overflow_err, 0);

        // Full FIFO with a pop coinciding with an arriving row.
        for (int r = 0; r < 5; r++) cycle(1'b1, rand_row(), 1'b0, 1'b0);
        for (int j = 1; j <= N + 3; j++) cycle(1'b0, rand_row(), j == N, 1'b0);
        @(negedge clk);
        check("full_pop_afull", fifo_afull, 1);
        check("full_pop_noerr", overflow_err, 0);

        // Drop coinciding with err_clr keeps the flag set.
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        for (int j = 1; j <= N + 2; j++) cycle(1'b0, rand_row(), 1'b0, j == N);
        @(negedge clk);
        check("clr_vs_drop", overflow_err, 1);
        cycle(1'b0, rand_row(), 1'b0, 1'b1);
        cycle(1'b0, rand_row(), 1'b0, 1'b0);
        @(negedge clk);
        check("clr_alone", overflow_err, 0);
        for (int c = 0; c < N; c++) cycle(1'b0, rand_row(), 1'b1, 1'b0);

        // Asynchronous reset while a row is in flight and the FIFO holds data.
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        for (int c = 0; c < N + 2; c++) cycle(1'b0, rand_row(), 1'b0, 1'b0);
        cycle(1'b1, rand_row(), 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            cycle(1'b0, rand_row(), 1'b0, 1'b0);
            if (j == 4) begin
                #2 reset = 1'b1;
                #1;
                check("arst_valid", out_valid, 0);
                check("arst_data", out_data, 0);
                check("arst_afull", fifo_afull, 0);
                check("arst_busy", busy, 0);
                check("arst_err", overflow_err, 0);
            end
            if (j == 6) #2 reset = 1'b0;
        end
        for (int c = 0; c < N + 4; c++) cycle(1'b0, rand_row(), 1'b1, 1'b0);
        a = '{-1, 2, -3, 4, -5, 6, -7, 8};
        run_single("post_rst", mk_acc(a), 0, mk_act(a));

        // Random traffic; shift amount only changes once everything has drained.
        for (int blk = 0; blk < 5; blk++) begin
            shift_amt = 5'($urandom_range(0, 31));
            for (int c = 0; c < 80; c++) begin
                cycle($urandom_range(0, 99) < 60, rand_row(), $urandom_range(0, 99) < 55,
                      $urandom_range(0, 99) < 8);
            end
            for (int c = 0; c < N + DEPTH + 4; c++) cycle(1'b0, rand_row(), 1'b1, 1'b0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
